muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values are even and at least 8.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, request strobe, sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 3, operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-007 The block SHALL have ports a and b, input, WIDTH each; a is the multiplicand/dividend/move source, b is the multiplier/divisor.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in flight.
REQ-009 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have ports hi and lo, output, WIDTH each, architectural HI/LO registers.
REQ-011 The block SHALL have port div_by_zero, output, 1, sticky flag for the last divide; cleared by the next accepted start.

Function
REQ-012 The state machine SHALL have the states IDLE, CALC and FIX.
REQ-013 In IDLE with start=1, the block SHALL latch op, a and b at that edge (edge 0), set busy=1, and go to CALC with the counter at WIDTH.
REQ-014 Each CALC edge SHALL perform one iteration: shift-add for multiply, restoring shift-subtract for divide; the FSM SHALL go to FIX after WIDTH iterations (edges 1..WIDTH).
REQ-015 The FIX edge (WIDTH+1) SHALL apply sign correction, write hi/lo, and set done=1 and busy=0, with the FSM returning to IDLE.
REQ-016 done SHALL be high for exactly the one cycle after the FIX edge, coincident with the new hi/lo values.
REQ-017 MULT/MULTU SHALL produce hi = upper WIDTH bits and lo = lower WIDTH bits of the 2*WIDTH-bit product.
REQ-018 Signed ops SHALL operate on magnitudes in CALC; the product SHALL be negated in FIX when the operand signs differ.
REQ-019 DIV/DIVU SHALL produce lo = quotient truncated toward zero and hi = remainder.
REQ-020 For signed divide, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-021 A divide with b=0 SHALL give hi=a, lo=all ones and div_by_zero=1, with the same latency as a normal divide.
REQ-022 Signed divide of the most-negative value by -1 SHALL give lo = most-negative value and hi = 0, with no flag.
REQ-023 MTHI/MTLO SHALL be single-cycle: at the accepting edge, hi (or lo) = a, done=1 the next cycle, busy stays 0, and the other register is unchanged.
REQ-024 start while busy=1 SHALL be ignored, with no effect on state, operands or results.
REQ-025 An undefined op code SHALL be accepted as a no-op: done pulses one cycle later and hi/lo are unchanged.
REQ-026 hi/lo SHALL change only at FIX or MTHI/MTLO edges; intermediate accumulators SHALL NOT be visible on hi/lo.

Reset
REQ-027 With reset=0 at a rising edge, the block SHALL return to IDLE and set hi=0, lo=0, busy=0, done=0, div_by_zero=0 and counter=0.
REQ-028 Reset during CALC or FIX SHALL abort the operation, with no done pulse and no partial hi/lo write.
REQ-029 reset SHALL take priority over start at the same edge.

Structure
REQ-030 The op encodings, the state enum and the default WIDTH SHALL reside in a shared package, muldiv_pkg, which the controller also imports.
REQ-031 The block SHALL contain one sub-module, muldiv_abs (combinational two's-complement magnitude plus sign output, WIDTH-parameterised), instanced for a and for b.
REQ-032 The datapath SHALL use a single 2*WIDTH+1-bit shift register shared between multiply and divide, and no combinational array multiplier or divider.

Verification
REQ-033 The bench SHALL cover: WIDTH=32, MULT a=0xFFFFFFFE, b=3 -> done in the cycle after edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 The bench SHALL cover: MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 The bench SHALL cover: DIVU a=7, b=0 -> hi=7, lo=0xFFFFFFFF, div_by_zero=1; a following MULTU 2*3 -> div_by_zero=0, lo=6.
REQ-036 The bench SHALL cover: a MULT start followed by a DIVU start at edge 5 -> the second start is ignored, a single done pulse occurs, and the results are the MULT results.
REQ-037 The bench SHALL cover: MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> done one cycle after each; hi/lo hold those values; a reset at edge 10 of a following DIV -> hi=lo=0, busy=0, no done.
REQ-038 The bench SHALL cover: WIDTH=8, DIV a=0x80, b=0xFF -> lo=0x80, hi=0x00, done in the cycle after edge 9.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and the default operand width.
package muldiv_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  function automatic logic op_is_signed(logic [2:0] op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

  function automatic logic op_is_iterative(logic [2:0] op);
    return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Two's-complement magnitude of an operand; sign is only honoured for signed ops.
module muldiv_abs import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             neg_o
);

  assign neg_o = signed_i & val_i[WIDTH-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign mag_o = neg_o ? ((~val_i) + WIDTH'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers; one
// shared shift register carries both the shift-add and restoring-divide state.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned AccW = 2 * WIDTH + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;

  assign op_signed = op_is_signed(op);

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val_i    (a),
    .signed_i (op_signed),
    .mag_o    (a_mag),
    .neg_o    (a_neg)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val_i    (b),
    .signed_i (op_signed),
    .mag_o    (b_mag),
    .neg_o    (b_neg)
  );

  // Multiply step: conditionally add the multiplicand into the upper half, shift right.
  logic [WIDTH:0]  mul_sum;
  logic [AccW-1:0] mul_next;
  assign mul_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: shift the next dividend bit into the remainder, subtract if it fits.
  logic [WIDTH:0]  rem_sh, rem_new;
  logic            rem_ge;
  logic [AccW-1:0] div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = rem_sh >= {1'b0, opb_q};
  assign rem_new  = rem_ge ? (rem_sh - {1'b0, opb_q}) : rem_sh;
  assign div_next = {rem_new, acc_q[WIDTH-2:0], rem_ge};

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;
  logic               dbz_fix;
  assign prod     = acc_q[2*WIDTH-1:0];
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  assign quo_fix  = neg_res_q ? -quo : quo;
  assign rem_fix  = neg_rem_q ? -rem : rem;
  assign dbz_fix  = (opb_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dbz_d = 1'b0;
          if (op_is_iterative(op)) begin
            state_d   = StCalc;
            cnt_d     = CNT_W'(WIDTH);
            acc_d     = {{(WIDTH + 1){1'b0}}, a_mag};
            opb_d     = b_mag;
            is_div_d  = (op == OpDiv) || (op == OpDivu);
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end else begin
            // Moves and undefined codes complete immediately.
            done_d = 1'b1;
            if (op == OpMthi) hi_d = a;
            if (op == OpMtlo) lo_d = a;
          end
        end
      end
      StCalc: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d  = rem_fix;
          lo_d  = dbz_fix ? '1 : quo_fix;
          dbz_d = dbz_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start32, busy32, done32, dbz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        start8, busy8, done8, dbz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_by_zero(dbz32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference architectural state, index 0 = WIDTH 32, index 1 = WIDTH 8.
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  logic        m_dbz[2];

  function automatic logic [31:0] get_hi(int s);
    return (s != 0) ? {24'b0, hi8} : hi32;
  endfunction
  function automatic logic [31:0] get_lo(int s);
    return (s != 0) ? {24'b0, lo8} : lo32;
  endfunction
  function automatic logic get_busy(int s);
    return (s != 0) ? busy8 : busy32;
  endfunction
  function automatic logic get_done(int s);
    return (s != 0) ? done8 : done32;
  endfunction
  function automatic logic get_dbz(int s);
    return (s != 0) ? dbz8 : dbz32;
  endfunction

  task automatic drive(input int s, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (s != 0) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = st; op32 = op; a32 = a; b32 = b;
    end
  endtask

  // Plain-arithmetic reference: SV signed / and % truncate toward zero.
  function automatic void ref_op(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi_in, input logic [31:0] lo_in,
                                 output logic [31:0] hi_o, output logic [31:0] lo_o,
                                 output logic dbz_o);
    logic signed [127:0] sa, sb, p, q, r;
    logic [31:0] m;
    bit sgn;
    m   = 32'((64'd1 << w) - 64'd1);
    sgn = (op == OpMult) || (op == OpDiv);
    sa  = 128'(a & m);
    sb  = 128'(b & m);
    if (sgn && a[w-1]) sa = sa - (128'sd1 <<< w);
    if (sgn && b[w-1]) sb = sb - (128'sd1 <<< w);
    hi_o  = hi_in;
    lo_o  = lo_in;
    dbz_o = 1'b0;
    case (op)
      OpMult, OpMultu: begin
        p    = sa * sb;
        lo_o = 32'(p) & m;
        hi_o = 32'(p >>> w) & m;
      end
      OpDiv, OpDivu: begin
        if (sb == 0) begin
          hi_o  = a & m;
          lo_o  = m;
          dbz_o = 1'b1;
        end else begin
          q    = sa / sb;
          r    = sa % sb;
          lo_o = 32'(q) & m;
          hi_o = 32'(r) & m;
        end
      end
      OpMthi:  hi_o = a & m;
      OpMtlo:  lo_o = a & m;
      default: ;
    endcase
  endfunction

  task automatic do_op(input int s, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string name);
    int w, lat, k;
    bit seen;
    logic [31:0] ehi, elo, old_hi, old_lo;
    logic edbz;
    w      = (s != 0) ? 8 : 32;
    lat    = (op <= OpDivu) ? w + 1 : 0;
    old_hi = m_hi[s];
    old_lo = m_lo[s];
    ref_op(w, op, a, b, old_hi, old_lo, ehi, elo, edbz);
    @(negedge clk); drive(s, 1'b1, op, a, b);
    @(posedge clk);
    @(negedge clk); drive(s, 1'b0, 3'($urandom), $urandom, $urandom);
    k = 0;
    seen = 0;
    while (!seen && k <= w + 4) begin
      if (get_done(s)) seen = 1;
      else begin
        if (lat > 0 && k == 2) begin
          n_checks++;
          if (get_busy(s) !== 1'b1) $display("FAIL %s busy mid-op got %0b want 1", name, get_busy(s));
          else n_pass++;
          n_checks++;
          if (get_hi(s) !== old_hi || get_lo(s) !== old_lo)
            $display("FAIL %s hi/lo mid-op got %h/%h want %h/%h", name, get_hi(s), get_lo(s), old_hi, old_lo);
          else n_pass++;
        end
        @(posedge clk); @(negedge clk); k++;
      end
    end
    n_checks++;
    if (!seen || k != lat) $display("FAIL %s latency got %0d (seen=%0b) want %0d", name, k, seen, lat);
    else n_pass++;
    n_checks++;
    if (get_hi(s) !== ehi) $display("FAIL %s hi got %h want %h", name, get_hi(s), ehi);
    else n_pass++;
    n_checks++;
    if (get_lo(s) !== elo) $display("FAIL %s lo got %h want %h", name, get_lo(s), elo);
    else n_pass++;
    n_checks++;
    if (get_dbz(s) !== edbz) $display("FAIL %s div_by_zero got %0b want %0b", name, get_dbz(s), edbz);
    else n_pass++;
    n_checks++;
    if (get_busy(s) !== 1'b0) $display("FAIL %s busy at done got %0b want 0", name, get_busy(s));
    else n_pass++;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (get_done(s) !== 1'b0) $display("FAIL %s done width got %0b want 0", name, get_done(s));
    else n_pass++;
    m_hi[s]  = ehi;
    m_lo[s]  = elo;
    m_dbz[s] = edbz;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(0, 1'b1, OpMult, 32'h5, 32'h7);
    drive(1, 1'b1, OpMthi, 32'h5, 32'h7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (get_hi(s) !== 32'h0 || get_lo(s) !== 32'h0)
        $display("FAIL reset%0d hi/lo got %h/%h want 0/0", s, get_hi(s), get_lo(s));
      else n_pass++;
      n_checks++;
      if (get_busy(s) !== 1'b0 || get_done(s) !== 1'b0 || get_dbz(s) !== 1'b0)
        $display("FAIL reset%0d busy/done/dbz got %0b%0b%0b want 000", s, get_busy(s), get_done(s), get_dbz(s));
      else n_pass++;
      m_hi[s] = '0; m_lo[s] = '0; m_dbz[s] = 1'b0;
    end
    drive(0, 1'b0, OpMult, 0, 0);
    drive(1, 1'b0, OpMult, 0, 0);
    reset = 1'b1;
  endtask

  task automatic test_directed;
    do_op(0, OpMult,  32'hFFFFFFFE, 32'h3,        "mult_neg2x3");
    do_op(0, OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    do_op(0, OpDiv,   32'hFFFFFFF9, 32'h2,        "div_m7_2");
    do_op(0, OpDivu,  32'h7,        32'h0,        "divu_by0");
    do_op(0, OpMultu, 32'h2,        32'h3,        "multu_2x3");
    do_op(0, OpDiv,   32'h80000000, 32'hFFFFFFFF, "div_min_m1");
    do_op(0, OpDiv,   32'hFFFFFFF9, 32'h0,        "div_neg_by0");
    do_op(1, OpDiv,   32'h80,       32'hFF,       "w8_div_min_m1");
    do_op(1, OpMult,  32'h80,       32'h80,       "w8_mult_min2");
  endtask

  task automatic test_moves_undef;
    do_op(0, OpMthi, 32'h12345678, 32'hDEAD0000, "mthi");
    do_op(0, OpMtlo, 32'h9ABCDEF0, 32'hDEAD0001, "mtlo");
    do_op(0, 3'd6,   32'h11111111, 32'h22222222, "undef6");
    do_op(1, 3'd7,   32'h33,       32'h44,       "w8_undef7");
  endtask

  task automatic test_busy_ignore;
    logic [31:0] ehi, elo;
    logic edbz;
    int ndone, first;
    ref_op(32, OpMult, 32'h00012345, 32'hFFFF0003, m_hi[0], m_lo[0], ehi, elo, edbz);
    @(negedge clk); drive(0, 1'b1, OpMult, 32'h00012345, 32'hFFFF0003);
    @(posedge clk);
    @(negedge clk); drive(0, 1'b0, OpMult, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk); drive(0, 1'b1, OpDivu, 32'h64, 32'h0);
    @(posedge clk);
    @(negedge clk); drive(0, 1'b0, OpDivu, 0, 0);
    ndone = 0;
    first = -1;
    for (int k = 5; k < 80; k++) begin
      if (done32) begin
        ndone++;
        if (first < 0) first = k;
      end
      @(posedge clk); @(negedge clk);
    end
    n_checks++;
    if (ndone != 1 || first != 33) $display("FAIL busy_ignore done count %0d at %0d want 1 at 33", ndone, first);
    else n_pass++;
    n_checks++;
    if (hi32 !== ehi || lo32 !== elo) $display("FAIL busy_ignore hi/lo got %h/%h want %h/%h", hi32, lo32, ehi, elo);
    else n_pass++;
    n_checks++;
    if (dbz32 !== 1'b0) $display("FAIL busy_ignore div_by_zero got %0b want 0", dbz32);
    else n_pass++;
    m_hi[0] = ehi; m_lo[0] = elo; m_dbz[0] = edbz;
  endtask

  task automatic test_reset_abort;
    int ndone;
    @(negedge clk); drive(0, 1'b1, OpDiv, 32'h7FFF0000, 32'h3);
    @(posedge clk);
    @(negedge clk); drive(0, 1'b0, OpDiv, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy32 !== 1'b1) $display("FAIL abort busy before reset got %0b want 1", busy32);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      m_hi[s] = '0; m_lo[s] = '0; m_dbz[s] = 1'b0;
    end
    n_checks++;
    if (hi32 !== 32'h0 || lo32 !== 32'h0) $display("FAIL abort hi/lo got %h/%h want 0/0", hi32, lo32);
    else n_pass++;
    n_checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0) $display("FAIL abort busy/done got %0b/%0b want 0/0", busy32, done32);
    else n_pass++;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done32 || hi32 !== 32'h0 || lo32 !== 32'h0) ndone++;
      @(posedge clk); @(negedge clk);
    end
    n_checks++;
    if (ndone != 0) $display("FAIL abort late done/write cycles got %0d want 0", ndone);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      int s;
      s  = (i % 3 == 2) ? 1 : 0;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: begin a = (s != 0) ? 32'h80 : 32'h80000000; b = 32'hFFFFFFFF; end
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(s, op, a, b, $sformatf("rand%0d_w%0d_op%0d", i, (s != 0) ? 8 : 32, op));
    end
  endtask

  initial begin
    drive(0, 1'b0, OpMult, 0, 0);
    drive(1, 1'b0, OpMult, 0, 0);
    test_reset();
    test_directed();
    test_moves_undef();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
